// File: rtl/calc_seq.sv
// calc_seq: bit-serial neuron sequencer.
// Latches an activation/weight vector pair, streams them LSB first to an
// external calc stage and captures the activated sign bit it returns.
// Optional feature: define CALC_SEQ_MATCH_CNT_EN to add the match_cnt output,
// which counts the streamed cycles where the activation and weight bits agree.
module calc_seq #(
    parameter int VEC_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [VEC_LEN-1:0] act_vec,
    input  logic [VEC_LEN-1:0] wgt_vec,
    input  logic               acted_in,
    output logic               calc_1,
    output logic               calc_in,
    output logic               calc_clr,
    output logic               busy,
    output logic               done,
    output logic               result
`ifdef CALC_SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        SETTLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VEC_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_LEN-1:0] act_sh_q, act_sh_d;
    logic [VEC_LEN-1:0] wgt_sh_q, wgt_sh_d;
    logic               result_q, result_d;
`ifdef CALC_SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_q, match_d;
`endif

    // Next-state logic: sequencing, shifting, counting and result capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_sh_d = act_sh_q;
        wgt_sh_d = wgt_sh_q;
        result_d = result_q;
`ifdef CALC_SEQ_MATCH_CNT_EN
        match_d  = match_q;
`endif
        case (state_q)
            IDLE: begin
                // start beats abort here; abort is meaningless while idle.
                if (start) begin
                    act_sh_d = act_vec;
                    wgt_sh_d = wgt_vec;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = '0;
`ifdef CALC_SEQ_MATCH_CNT_EN
                match_d = '0;
`endif
                state_d = abort ? IDLE : STREAM;
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    act_sh_d = act_sh_q >> 1;
                    wgt_sh_d = wgt_sh_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
`ifdef CALC_SEQ_MATCH_CNT_EN
                    if (act_sh_q[0] == wgt_sh_q[0]) begin
                        match_d = match_q + CNT_W'(1);
                    end
`endif
                    if (cnt_q == LAST_BIT) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // An abort here discards the capture so result keeps its value.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    result_d = acted_in;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            // NOTE: the shift registers are reset as well so a reset mid-run
            // leaves no stale operand bits behind.
            act_sh_q <= '0;
            wgt_sh_q <= '0;
            result_q <= 1'b0;
`ifdef CALC_SEQ_MATCH_CNT_EN
            match_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_sh_q <= act_sh_d;
            wgt_sh_q <= wgt_sh_d;
            result_q <= result_d;
`ifdef CALC_SEQ_MATCH_CNT_EN
            match_q  <= match_d;
`endif
        end
    end

    // Output decode from registered state only; no input reaches an output.
    always_comb begin
        calc_1   = 1'b0;
        calc_in  = 1'b0;
        calc_clr = 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        case (state_q)
            STREAM: begin
                calc_1  = act_sh_q[0];
                calc_in = wgt_sh_q[0];
            end
            SETTLE: begin
                calc_clr = 1'b0;
            end
            default: begin
                calc_clr = 1'b1;
            end
        endcase
    end

    assign result = result_q;
`ifdef CALC_SEQ_MATCH_CNT_EN
    assign match_cnt = match_q;
`endif

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed self-checking bench for calc_seq (VEC_LEN=16).
// Cycle numbering: the edge that samples start is edge 0, CLEAR is cycle 1,
// STREAM cycles 2..17, SETTLE cycle 18, DONE cycle 19.
module tb_calc_seq;

    localparam int VEC_LEN = 16;
    localparam int CNT_W   = 5;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic [VEC_LEN-1:0] act_vec;
    logic [VEC_LEN-1:0] wgt_vec;
    logic               acted_in;
    logic               calc_1;
    logic               calc_in;
    logic               calc_clr;
    logic               busy;
    logic               done;
    logic               result;
`ifdef CALC_SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    int   total;
    int   bad;
    logic res_model;

    calc_seq #(.VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .act_vec  (act_vec),
        .wgt_vec  (wgt_vec),
        .acted_in (acted_in),
        .calc_1   (calc_1),
        .calc_in  (calc_in),
        .calc_clr (calc_clr),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef CALC_SEQ_MATCH_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full evaluation; on return the DUT is in the IDLE cycle after DONE.
    task automatic run(input logic [15:0] act, input logic [15:0] wgt,
                       input logic want, input logic ab, input int exp_m);
        logic e1, ei, strm;
        check("idle_busy", busy, 0);
        check("idle_clr", calc_clr, 1);
        act_vec = act;
        wgt_vec = wgt;
        start   = 1'b1;
        abort   = ab;
        step();
        start   = 1'b0;
        abort   = 1'b0;
        act_vec = ~act;
        wgt_vec = ~wgt;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            strm = (cyc >= 2) && (cyc <= 17);
            e1   = strm ? act[cyc-2] : 1'b0;
            ei   = strm ? wgt[cyc-2] : 1'b0;
            check($sformatf("busy c%0d", cyc), busy, 1);
            check($sformatf("done c%0d", cyc), done, (cyc == 19));
            check($sformatf("clr c%0d", cyc), calc_clr, (cyc == 1 || cyc == 19));
            check($sformatf("calc_1 c%0d", cyc), calc_1, e1);
            check($sformatf("calc_in c%0d", cyc), calc_in, ei);
            if (cyc == 10) check("result_hold", result, res_model);
            acted_in = (cyc == 18) ? want : ~want;
            if (cyc == 19) begin
                res_model = want;
                check("result", result, want);
`ifdef CALC_SEQ_MATCH_CNT_EN
                check("match_cnt", match_cnt, exp_m);
`endif
            end
            step();
        end
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    // Start a run, re-assert start at cycle 5, abort at cycle ab_cyc.
    task automatic abort_test(input int ab_cyc);
        logic seen_done;
        act_vec = 16'h5A3C;
        wgt_vec = 16'hC3A5;
        start   = 1'b1;
        step();
        for (int cyc = 1; cyc <= ab_cyc; cyc++) begin
            start    = (cyc == 5);
            abort    = (cyc == ab_cyc);
            acted_in = ~res_model;
            check($sformatf("ab%0d busy c%0d", ab_cyc, cyc), busy, 1);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        check($sformatf("ab%0d busy_off", ab_cyc), busy, 0);
        check($sformatf("ab%0d clr", ab_cyc), calc_clr, 1);
        check($sformatf("ab%0d result", ab_cyc), result, res_model);
        seen_done = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (done || busy) seen_done = 1'b1;
            step();
        end
        check($sformatf("ab%0d no_done", ab_cyc), seen_done, 0);
    endtask

    initial begin
        logic seen;
        total     = 0;
        bad       = 0;
        res_model = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        act_vec   = '0;
        wgt_vec   = '0;
        acted_in  = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr", calc_clr, 1);
        check("rst_c1", calc_1, 0);
        check("rst_cin", calc_in, 0);
        check("rst_result", result, 0);
        step();
        rst = 1'b1;

        // First start right after reset release; basic A5A5/FFFF run.
        run(16'hA5A5, 16'hFFFF, 1'b1, 1'b0, 8);
        // Back-to-back, no gap: 00FF vs 0F0F agree on 8 bits.
        run(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 8);
        // Simultaneous start and abort in IDLE; identical vectors match 16.
        run(16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 16);

        // Abort in STREAM, SETTLE and CLEAR.
        abort_test(10);
        abort_test(18);
        abort_test(1);

        // Reset mid-STREAM at cycle 8.
        act_vec = 16'hFFFF;
        wgt_vec = 16'hFFFF;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_c1", calc_1, 1);
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_clr", calc_clr, 1);
        check("mrst_c1", calc_1, 0);
        check("mrst_cin", calc_in, 0);
        check("mrst_result", result, 0);
        res_model = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (done || busy) seen = 1'b1;
            if (i == 2) rst = 1'b1;
        end
        check("mrst_no_done", seen, 0);

        // Normal operation resumes after the mid-run reset.
        run(16'h8001, 16'h7FFE, 1'b1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
